// File: rtl/bira_fault_cam_p_if.sv
// Dump stream between the fault CAM and the spare-allocation stage.
// The master drives one stored entry per word; the slave accepts with out_ready.
interface bira_fault_cam_p_if #(
  parameter int ROW_W = 10,
  parameter int COL_W = 10,
  parameter int BNK_W = 2,
  parameter int PAR_W = 3
);
  logic             out_valid;
  logic             out_ready;
  logic             out_is_piv;
  logic [BNK_W-1:0] out_bank;
  logic [ROW_W-1:0] out_row;
  logic [COL_W-1:0] out_col;
  logic [PAR_W-1:0] out_parent;
  logic [1:0]       out_mr;
  logic             out_last;

  modport master (
    output out_valid, out_is_piv, out_bank, out_row, out_col,
           out_parent, out_mr, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_is_piv, out_bank, out_row, out_col,
           out_parent, out_mr, out_last,
    output out_ready
  );
endinterface

// File: rtl/bira_fault_cam_p.sv
// Fault-collection CAM for built-in redundancy analysis.
// Faults are classified as pivots (fresh row and column in their bank) or
// non-pivots (sharing a line with a stored pivot); pivots carry saturating
// row/column share counts that drive must-repair flags. On test end the list
// is streamed out, pivots first, over the dump interface.
module bira_fault_cam_p #(
  parameter int ROW_W = 10,
  parameter int COL_W = 10,
  parameter int BNK_W = 2,
  parameter int N_PIV = 8,
  parameter int N_NPV = 10,
  parameter int CNT_W = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         fault_detect,
  input  logic [ROW_W-1:0]             row_addr,
  input  logic [COL_W-1:0]             col_addr,
  input  logic [BNK_W-1:0]             bank_addr,
  input  logic                         test_end,
  input  logic [CNT_W-1:0]             mr_row_th,
  input  logic [CNT_W-1:0]             mr_col_th,
  output logic                         early_term,
  output logic [$clog2(N_PIV+1)-1:0]   piv_cnt,
  output logic [$clog2(N_NPV+1)-1:0]   npv_cnt,
  output logic                         done,
  bira_fault_cam_p_if.master           dump
);

  localparam int PCNT_W = $clog2(N_PIV + 1);
  localparam int NCNT_W = $clog2(N_NPV + 1);
  localparam int PAR_W  = (N_PIV > 1) ? $clog2(N_PIV) : 1;
  localparam int TOT_W  = $clog2(N_PIV + N_NPV + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {ST_COLLECT, ST_DUMP, ST_DONE} state_t;
  state_t state_reg, state_next;

  // Pivot table
  logic [BNK_W-1:0] piv_bank_reg [N_PIV];
  logic [ROW_W-1:0] piv_row_reg  [N_PIV];
  logic [COL_W-1:0] piv_col_reg  [N_PIV];
  logic [CNT_W-1:0] row_cnt_reg  [N_PIV];
  logic [CNT_W-1:0] col_cnt_reg  [N_PIV];

  // Non-pivot table
  logic [BNK_W-1:0] npv_bank_reg   [N_NPV];
  logic [ROW_W-1:0] npv_row_reg    [N_NPV];
  logic [COL_W-1:0] npv_col_reg    [N_NPV];
  logic [PAR_W-1:0] npv_parent_reg [N_NPV];

  logic [PCNT_W-1:0] piv_cnt_reg;
  logic [NCNT_W-1:0] npv_cnt_reg;
  logic              early_term_reg;
  logic [TOT_W-1:0]  rd_idx_reg;

  logic [N_PIV-1:0] piv_row_hit, piv_col_hit, piv_exact;
  logic [N_PIV-1:0] row_mr, col_mr;
  logic [N_NPV-1:0] npv_exact;

  logic             fault_take, hit_exact, hit_share;
  logic             store_piv, store_npv, overflow;
  logic [PAR_W-1:0] parent_idx;
  logic [TOT_W-1:0] total;
  logic             dump_valid, is_last;

  logic             sel_is_piv;
  logic [BNK_W-1:0] sel_bank;
  logic [ROW_W-1:0] sel_row;
  logic [COL_W-1:0] sel_col;
  logic [PAR_W-1:0] sel_parent;
  logic [1:0]       sel_mr;

  // Parallel compare against every valid pivot, plus live must-repair flags
  genvar gi;
  generate
    for (gi = 0; gi < N_PIV; gi++) begin : g_piv_cmp
      logic piv_vld;
      logic bank_eq;
      assign piv_vld         = (PCNT_W'(gi) < piv_cnt_reg);
      assign bank_eq         = piv_vld && (piv_bank_reg[gi] == bank_addr);
      assign piv_row_hit[gi] = bank_eq && (piv_row_reg[gi] == row_addr);
      assign piv_col_hit[gi] = bank_eq && (piv_col_reg[gi] == col_addr);
      assign piv_exact[gi]   = piv_row_hit[gi] && piv_col_hit[gi];
      assign row_mr[gi]      = row_cnt_reg[gi] > mr_row_th;
      assign col_mr[gi]      = col_cnt_reg[gi] > mr_col_th;
    end
    for (gi = 0; gi < N_NPV; gi++) begin : g_npv_cmp
      assign npv_exact[gi] = (NCNT_W'(gi) < npv_cnt_reg) &&
                             (npv_bank_reg[gi] == bank_addr) &&
                             (npv_row_reg[gi] == row_addr) &&
                             (npv_col_reg[gi] == col_addr);
    end
  endgenerate

  // A fault on an already-listed address is dropped; a fault whose table is
  // full is discarded entirely (no count update) and trips early termination.
  assign fault_take = (state_reg == ST_COLLECT) && fault_detect && !early_term_reg;
  assign hit_exact  = (|piv_exact) || (|npv_exact);
  assign hit_share  = (|piv_row_hit) || (|piv_col_hit);
  assign store_piv  = fault_take && !hit_exact && !hit_share &&
                      (piv_cnt_reg != PCNT_W'(N_PIV));
  assign store_npv  = fault_take && !hit_exact && hit_share &&
                      (npv_cnt_reg != NCNT_W'(N_NPV));
  assign overflow   = fault_take && !hit_exact &&
                      ((hit_share && (npv_cnt_reg == NCNT_W'(N_NPV))) ||
                       (!hit_share && (piv_cnt_reg == PCNT_W'(N_PIV))));

  // Parent: lowest row-matching pivot wins, else lowest column-matching pivot
  always_comb begin
    parent_idx = '0;
    for (int i = N_PIV - 1; i >= 0; i--)
      if (piv_col_hit[i]) parent_idx = PAR_W'(i);
    for (int i = N_PIV - 1; i >= 0; i--)
      if (piv_row_hit[i]) parent_idx = PAR_W'(i);
  end

  // Pivot storage and saturating share counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_PIV; i++) begin
        piv_bank_reg[i] <= '0;
        piv_row_reg[i]  <= '0;
        piv_col_reg[i]  <= '0;
        row_cnt_reg[i]  <= '0;
        col_cnt_reg[i]  <= '0;
      end
    end else if (clear) begin
      for (int i = 0; i < N_PIV; i++) begin
        row_cnt_reg[i] <= '0;
        col_cnt_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_PIV; i++) begin
        if (store_piv && (piv_cnt_reg == PCNT_W'(i))) begin
          piv_bank_reg[i] <= bank_addr;
          piv_row_reg[i]  <= row_addr;
          piv_col_reg[i]  <= col_addr;
          row_cnt_reg[i]  <= CNT_W'(1);
          col_cnt_reg[i]  <= CNT_W'(1);
        end
        if (store_npv && piv_row_hit[i] && (row_cnt_reg[i] != CNT_MAX))
          row_cnt_reg[i] <= row_cnt_reg[i] + CNT_W'(1);
        if (store_npv && piv_col_hit[i] && (col_cnt_reg[i] != CNT_MAX))
          col_cnt_reg[i] <= col_cnt_reg[i] + CNT_W'(1);
      end
    end
  end

  // Non-pivot storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < N_NPV; j++) begin
        npv_bank_reg[j]   <= '0;
        npv_row_reg[j]    <= '0;
        npv_col_reg[j]    <= '0;
        npv_parent_reg[j] <= '0;
      end
    end else if (!clear && store_npv) begin
      for (int j = 0; j < N_NPV; j++) begin
        if (npv_cnt_reg == NCNT_W'(j)) begin
          npv_bank_reg[j]   <= bank_addr;
          npv_row_reg[j]    <= row_addr;
          npv_col_reg[j]    <= col_addr;
          npv_parent_reg[j] <= parent_idx;
        end
      end
    end
  end

  // Occupancy counts, sticky overflow flag and dump read pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      piv_cnt_reg    <= '0;
      npv_cnt_reg    <= '0;
      early_term_reg <= 1'b0;
      rd_idx_reg     <= '0;
    end else if (clear) begin
      piv_cnt_reg    <= '0;
      npv_cnt_reg    <= '0;
      early_term_reg <= 1'b0;
      rd_idx_reg     <= '0;
    end else begin
      if (store_piv) piv_cnt_reg <= piv_cnt_reg + PCNT_W'(1);
      if (store_npv) npv_cnt_reg <= npv_cnt_reg + NCNT_W'(1);
      if (overflow)  early_term_reg <= 1'b1;
      if (dump_valid && dump.out_ready) rd_idx_reg <= rd_idx_reg + TOT_W'(1);
    end
  end

  assign total      = TOT_W'(piv_cnt_reg) + TOT_W'(npv_cnt_reg);
  assign dump_valid = (state_reg == ST_DUMP) && (total != '0);
  assign is_last    = (rd_idx_reg == total - TOT_W'(1));

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_COLLECT;
    else     state_reg <= state_next;
  end

  // FSM next state; an empty list skips straight to DONE
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_COLLECT: if (test_end)
                    state_next = ((piv_cnt_reg == '0) && !store_piv) ? ST_DONE : ST_DUMP;
      ST_DUMP:    if ((total == '0) || (dump_valid && dump.out_ready && is_last))
                    state_next = ST_DONE;
      ST_DONE:    state_next = ST_DONE;
      default:    state_next = ST_COLLECT;
    endcase
    if (clear) state_next = ST_COLLECT;
  end

  // Select the entry under the read pointer: pivots first, then non-pivots
  always_comb begin
    sel_is_piv = 1'b0;
    sel_bank   = '0;
    sel_row    = '0;
    sel_col    = '0;
    sel_parent = '0;
    sel_mr     = 2'b00;
    for (int i = 0; i < N_PIV; i++) begin
      if (rd_idx_reg == TOT_W'(i)) begin
        sel_is_piv = 1'b1;
        sel_bank   = piv_bank_reg[i];
        sel_row    = piv_row_reg[i];
        sel_col    = piv_col_reg[i];
        sel_mr     = {row_mr[i], col_mr[i]};
      end
    end
    for (int j = 0; j < N_NPV; j++) begin
      if (rd_idx_reg == TOT_W'(piv_cnt_reg) + TOT_W'(j)) begin
        sel_is_piv = 1'b0;
        sel_bank   = npv_bank_reg[j];
        sel_row    = npv_row_reg[j];
        sel_col    = npv_col_reg[j];
        sel_parent = npv_parent_reg[j];
        sel_mr     = 2'b00;
      end
    end
  end

  // FSM outputs; word fields read as zero whenever no word is offered
  always_comb begin
    dump.out_valid  = dump_valid;
    dump.out_is_piv = 1'b0;
    dump.out_bank   = '0;
    dump.out_row    = '0;
    dump.out_col    = '0;
    dump.out_parent = '0;
    dump.out_mr     = 2'b00;
    dump.out_last   = 1'b0;
    if (dump_valid) begin
      dump.out_is_piv = sel_is_piv;
      dump.out_bank   = sel_bank;
      dump.out_row    = sel_row;
      dump.out_col    = sel_col;
      dump.out_parent = sel_parent;
      dump.out_mr     = sel_mr;
      dump.out_last   = is_last;
    end
    done = (state_reg == ST_DONE);
  end

  assign early_term = early_term_reg;
  assign piv_cnt    = piv_cnt_reg;
  assign npv_cnt    = npv_cnt_reg;

endmodule

// File: tb/tb_bira_fault_cam_p.sv
// Scenario bench for bira_fault_cam_p: expected dump words are queued as the
// faults are applied and popped as the DUT hands words over.
module tb_bira_fault_cam_p;

  logic       clk = 1'b0;
  logic       rst, clear, fault_detect, test_end;
  logic [9:0] row_addr, col_addr;
  logic [1:0] bank_addr;
  logic [3:0] mr_row_th, mr_col_th;
  logic       early_term, done;
  logic [3:0] piv_cnt, npv_cnt;

  int checks   = 0;
  int failures = 0;

  typedef logic [28:0] word_t;  // {is_piv, bank, row, col, parent, mr, last}
  word_t exp_q[$];

  bira_fault_cam_p_if #(.ROW_W(10), .COL_W(10), .BNK_W(2), .PAR_W(3)) dif ();

  bira_fault_cam_p #(
    .ROW_W(10), .COL_W(10), .BNK_W(2), .N_PIV(8), .N_NPV(10), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear), .fault_detect(fault_detect),
    .row_addr(row_addr), .col_addr(col_addr), .bank_addr(bank_addr),
    .test_end(test_end), .mr_row_th(mr_row_th), .mr_col_th(mr_col_th),
    .early_term(early_term), .piv_cnt(piv_cnt), .npv_cnt(npv_cnt),
    .done(done), .dump(dif)
  );

  always #5 clk = ~clk;

  function automatic word_t mk(input logic p, input logic [1:0] b, input logic [9:0] r,
                               input logic [9:0] c, input logic [2:0] par,
                               input logic [1:0] mr, input logic l);
    return {p, b, r, c, par, mr, l};
  endfunction

  function automatic word_t obs();
    return {dif.out_is_piv, dif.out_bank, dif.out_row, dif.out_col,
            dif.out_parent, dif.out_mr, dif.out_last};
  endfunction

  task automatic fault(input logic [1:0] b, input logic [9:0] r, input logic [9:0] c);
    @(negedge clk);
    fault_detect = 1'b1; bank_addr = b; row_addr = r; col_addr = c;
    @(negedge clk);
    fault_detect = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    checks++;
    if ({early_term, piv_cnt, npv_cnt, done, dif.out_valid} !== 11'b0) begin
      failures++;
      $display("FAIL clear: got et=%b piv=%0d npv=%0d done=%b valid=%b, want all 0",
               early_term, piv_cnt, npv_cnt, done, dif.out_valid);
    end
  endtask

  task automatic check_counts(input string tag, input int piv, input int npv);
    checks++;
    if (piv_cnt !== 4'(piv) || npv_cnt !== 4'(npv)) begin
      failures++;
      $display("FAIL %s counts: got piv=%0d npv=%0d, want piv=%0d npv=%0d",
               tag, piv_cnt, npv_cnt, piv, npv);
    end
  endtask

  // Issue test_end, then consume the dump; stall selects ready pattern 1,0,0,1
  task automatic run_dump(input bit stall, input string tag);
    int    last_acc = -1;
    bit    held = 1'b0;
    bit    finished = 1'b0;
    word_t prev = '0;
    word_t w, e;
    @(negedge clk); test_end = 1'b1;
    @(negedge clk); test_end = 1'b0;
    for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
      dif.out_ready = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (cyc == 0 && exp_q.size() != 0) begin
        checks++;
        if (dif.out_valid !== 1'b1) begin
          failures++;
          $display("FAIL %s first_valid: got %b, want 1", tag, dif.out_valid);
        end
      end
      if (done === 1'b1) begin
        finished = 1'b1;
        checks++;
        if (cyc != last_acc + 1 || dif.out_valid !== 1'b0) begin
          failures++;
          $display("FAIL %s done_timing: got done at cycle %0d valid=%b, want cycle %0d valid=0",
                   tag, cyc, dif.out_valid, last_acc + 1);
        end
        checks++;
        if (exp_q.size() != 0) begin
          failures++;
          $display("FAIL %s missing_words: got %0d unsent, want 0", tag, exp_q.size());
        end
      end else if (dif.out_valid === 1'b1) begin
        w = obs();
        if (held) begin
          checks++;
          if (w !== prev) begin
            failures++;
            $display("FAIL %s stall_hold: got %h, want %h", tag, w, prev);
          end
        end
        if (dif.out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s extra_word: got %h, want none", tag, w);
          end else begin
            e = exp_q.pop_front();
            if (w !== e) begin
              failures++;
              $display("FAIL %s word: got %h, want %h", tag, w, e);
            end else begin
              $display("%s word accepted: %h", tag, w);
            end
          end
          last_acc = cyc;
          held = 1'b0;
        end else begin
          held = 1'b1;
          prev = w;
        end
      end
      if (!finished) @(negedge clk);
    end
    if (!finished) begin
      checks++; failures++;
      $display("FAIL %s timeout: got done=%b, want 1 within budget", tag, done);
    end
    dif.out_ready = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; fault_detect = 1'b0; test_end = 1'b0;
    row_addr = '0; col_addr = '0; bank_addr = '0;
    mr_row_th = 4'd1; mr_col_th = 4'd1; dif.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({early_term, piv_cnt, npv_cnt, done, dif.out_valid, dif.out_last, dif.out_mr} !== 14'b0) begin
      failures++;
      $display("FAIL reset: got et=%b piv=%0d npv=%0d done=%b valid=%b, want all 0",
               early_term, piv_cnt, npv_cnt, done, dif.out_valid);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    mr_row_th = 4'd1; mr_col_th = 4'd1;
    fault(2'd0, 10'd5, 10'd7); exp_q.push_back(mk(1, 0, 5, 7, 0, 2'b11, 0));
    fault(2'd0, 10'd5, 10'd9); exp_q.push_back(mk(0, 0, 5, 9, 0, 2'b00, 0));
    fault(2'd0, 10'd2, 10'd7); exp_q.push_back(mk(0, 0, 2, 7, 0, 2'b00, 1));
    check_counts("basic", 1, 2);
    run_dump(1'b0, "basic");
    do_clear();
  endtask

  task automatic test_duplicate();
    fault(2'd1, 10'd3, 10'd3);
    fault(2'd1, 10'd3, 10'd3);
    exp_q.push_back(mk(1, 1, 3, 3, 0, 2'b00, 1));
    check_counts("duplicate", 1, 0);
    run_dump(1'b0, "duplicate");
    do_clear();
  endtask

  task automatic test_bank();
    fault(2'd0, 10'd5, 10'd7);  exp_q.push_back(mk(1, 0, 5, 7, 0, 2'b00, 0));
    fault(2'd1, 10'd5, 10'd7);  exp_q.push_back(mk(1, 1, 5, 7, 0, 2'b10, 0));
    fault(2'd1, 10'd5, 10'd30); exp_q.push_back(mk(0, 1, 5, 30, 1, 2'b00, 1));
    check_counts("bank", 2, 1);
    run_dump(1'b0, "bank");
    do_clear();
  endtask

  task automatic test_overflow();
    mr_row_th = 4'd0; mr_col_th = 4'd0;
    for (int i = 0; i < 9; i++) begin
      fault(2'd0, 10'(i), 10'(i + 20));
      if (i < 8) exp_q.push_back(mk(1, 0, 10'(i), 10'(i + 20), 0, 2'b11, (i == 7)));
      if (i == 7) begin
        checks++;
        if (early_term !== 1'b0) begin
          failures++;
          $display("FAIL overflow early_term_8: got %b, want 0", early_term);
        end
      end
    end
    checks++;
    if (early_term !== 1'b1) begin
      failures++;
      $display("FAIL overflow early_term_9: got %b, want 1", early_term);
    end
    check_counts("overflow_9", 8, 0);
    fault(2'd1, 10'd100, 10'd100);
    check_counts("overflow_10", 8, 0);
    run_dump(1'b0, "overflow");
    do_clear();
    mr_row_th = 4'd1; mr_col_th = 4'd1;
  endtask

  task automatic test_stall_and_empty();
    fault(2'd0, 10'd5, 10'd7); exp_q.push_back(mk(1, 0, 5, 7, 0, 2'b11, 0));
    fault(2'd0, 10'd5, 10'd9); exp_q.push_back(mk(0, 0, 5, 9, 0, 2'b00, 0));
    fault(2'd0, 10'd2, 10'd7); exp_q.push_back(mk(0, 0, 2, 7, 0, 2'b00, 1));
    run_dump(1'b1, "stall");
    do_clear();
    run_dump(1'b0, "empty");
    do_clear();
  endtask

  task automatic test_rst_and_clear();
    fault(2'd2, 10'd10, 10'd11);
    fault(2'd2, 10'd12, 10'd13);
    @(negedge clk); test_end = 1'b1;
    @(negedge clk); test_end = 1'b0;
    checks++;
    if (dif.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL rst_dump valid_before: got %b, want 1", dif.out_valid);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({dif.out_valid, done, early_term, piv_cnt, npv_cnt} !== 11'b0) begin
      failures++;
      $display("FAIL rst_dump async: got valid=%b done=%b piv=%0d npv=%0d, want all 0",
               dif.out_valid, done, piv_cnt, npv_cnt);
    end
    @(negedge clk); rst = 1'b0;
    fault(2'd3, 10'd1, 10'd1);
    exp_q.push_back(mk(1, 3, 1, 1, 0, 2'b00, 1));
    check_counts("after_rst", 1, 0);
    run_dump(1'b0, "after_rst");
    do_clear();
    fault(2'd0, 10'd9, 10'd9);
    exp_q.push_back(mk(1, 0, 9, 9, 0, 2'b00, 1));
    check_counts("after_clear", 1, 0);
    run_dump(1'b0, "after_clear");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_duplicate();
    test_bank();
    test_overflow();
    test_stall_and_empty();
    test_rst_and_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
